cp0_timer_irq: RTL and testbench

Parametrised CP0 timer and interrupt-pending unit for the MIPS core.
- Provides Count, NUM_TIMERS Compare channels, programmable Count prescale, synchronised hardware interrupt lines, software IP bits, unmasked-interrupt detection and a highest-priority IP index for vectored dispatch.
- Sits beside the CP0 register file, which owns Status and forwards mtc0/mfc0 accesses to this block for Count, Compare and Cause.IP/TI.

---
 rtl/cp0_timer_irq.sv | 147 ++++++++++++++
 tb/tb_cp0_timer_irq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_irq.sv
// CP0 Count/Compare timers and Cause.IP/TI interrupt-pending logic.
// Status stays in the CP0 register file. This block drives Count, Compare and Cause and returns their read data.
module cp0_timer_irq #(
  parameter int NUM_TIMERS  = 1,
  parameter int COUNT_DIV   = 2,
  parameter int HW_INT      = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_IP    = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [HW_INT-1:0] int_in,
  input  logic              mtc0,
  input  logic [7:0]        addr,
  input  logic [31:0]       mtc0_data,
  output logic [31:0]       mfc0_data,
  input  logic [7:0]        status_im,
  input  logic              status_exl,
  input  logic              status_ie,
  output logic [7:0]        cause_ip,
  output logic              cause_ti,
  output logic [31:0]       count,
  output logic              int_sig,
  output logic [2:0]        int_vec
);

  localparam logic [7:0] ADDR_COUNT   = 8'h48;
  localparam logic [7:0] ADDR_COMPARE = 8'h58;
  localparam logic [7:0] ADDR_CAUSE   = 8'h68;

  localparam int               DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0]      div_q;
  logic [31:0]           count_q;
  logic [31:0]           compare_q [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] ti_q;
  logic [HW_INT-1:0]     sync_q [SYNC_STAGES];
  logic [7:0]            ip_q;

  logic                  wr_count;
  logic                  wr_cause;
  logic [NUM_TIMERS-1:0] wr_compare;
  logic                  tick;
  logic [HW_INT-1:0]     hw_s;
  logic [5:0]            hw_ip;
  logic [7:0]            ip_masked;

  // Write decode; Compare sels at or beyond NUM_TIMERS match nothing.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_count   = mtc0 && (addr == ADDR_COUNT);
    wr_cause   = mtc0 && (addr == ADDR_CAUSE);
    wr_compare = '0;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      wr_compare[k] = mtc0 && (addr == ADDR_COMPARE + 8'(k));
    end
  end

  assign tick = (div_q == DIV_LAST);

  // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      div_q   <= '0;
    end else if (wr_count) begin
      count_q <= mtc0_data;
      div_q   <= '0;
    end else if (tick) begin
      count_q <= count_q + 32'd1;
      div_q   <= '0;
    end else begin
      div_q   <= div_q + DIV_W'(1);
    end
  end

  // Match uses the registered count, so ti rises one edge after count reaches compare.
  // NOTE: the compare array is a handful of flops, so it takes the async reset like everything else.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_TIMERS; k++) compare_q[k] <= '1;
      ti_q <= '0;
    end else begin
      for (int k = 0; k < NUM_TIMERS; k++) begin
        if (wr_compare[k]) begin
          compare_q[k] <= mtc0_data;
          ti_q[k]      <= 1'b0;
        end else if (count_q == compare_q[k]) begin
          ti_q[k]      <= 1'b1;
        end
      end
    end
  end

  assign cause_ti = |ti_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    hw_ip                 = '0;
    hw_ip[HW_INT-1:0]     = hw_s;
    hw_ip[TIMER_IP-2]     = hw_ip[TIMER_IP-2] | cause_ti;
  end

  // IP7..2 track hardware every cycle; IP1..0 change only on a Cause write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ip_q <= '0;
    end else begin
      ip_q[7:2] <= hw_ip;
      if (wr_cause) ip_q[1:0] <= mtc0_data[9:8];
    end
  end

  assign cause_ip  = ip_q;
  assign count     = count_q;
  assign ip_masked = ip_q & status_im;
  assign int_sig   = (|ip_masked) & status_ie & ~status_exl;

  // Later (higher) bits overwrite earlier ones, giving IP7 top priority.
  always_comb begin
    int_vec = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ip_masked[i]) int_vec = 3'(i);
    end
  end

  always_comb begin
    mfc0_data = '0;
    if (addr == ADDR_COUNT) mfc0_data = count_q;
    if (addr == ADDR_CAUSE) mfc0_data = {1'b0, cause_ti, 14'd0, ip_q, 8'd0};
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (addr == ADDR_COMPARE + 8'(k)) mfc0_data = compare_q[k];
    end
  end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Directed bench for cp0_timer_irq: a 2-timer /2 instance plus a 1-timer /1 instance on a shared bus.
module tb_cp0_timer_irq;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  int_in;
  logic        mtc0;
  logic [7:0]  addr;
  logic [31:0] mtc0_data;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;

  logic [31:0] m_rd, m_count, f_rd, f_count;
  logic [7:0]  m_ip, f_ip;
  logic        m_ti, f_ti, m_sig, f_sig;
  logic [2:0]  m_vec, f_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_timer_irq #(.NUM_TIMERS(2), .COUNT_DIV(2), .HW_INT(6), .SYNC_STAGES(2), .TIMER_IP(7)) u_dut (
    .clk(clk), .resetn(resetn), .int_in(int_in), .mtc0(mtc0), .addr(addr),
    .mtc0_data(mtc0_data), .mfc0_data(m_rd), .status_im(status_im),
    .status_exl(status_exl), .status_ie(status_ie), .cause_ip(m_ip),
    .cause_ti(m_ti), .count(m_count), .int_sig(m_sig), .int_vec(m_vec)
  );

  cp0_timer_irq #(.NUM_TIMERS(1), .COUNT_DIV(1), .HW_INT(6), .SYNC_STAGES(2), .TIMER_IP(7)) u_fast (
    .clk(clk), .resetn(resetn), .int_in(int_in), .mtc0(mtc0), .addr(addr),
    .mtc0_data(mtc0_data), .mfc0_data(f_rd), .status_im(status_im),
    .status_exl(status_exl), .status_ie(status_ie), .cause_ip(f_ip),
    .cause_ti(f_ti), .count(f_count), .int_sig(f_sig), .int_vec(f_vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write; returns at the falling edge right after the capturing rising edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    mtc0 = 1'b1; addr = a; mtc0_data = d;
    @(negedge clk);
    mtc0 = 1'b0; addr = 8'h00; mtc0_data = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, m_rd, exp);
    addr = 8'h00;
  endtask

  initial begin
    resetn = 1'b0; int_in = '0; mtc0 = 1'b0; addr = '0; mtc0_data = '0;
    status_im = 8'h80; status_exl = 1'b0; status_ie = 1'b1;

    // Reset state
    cyc(2);
    check("rst_count", m_count, 32'd0);
    check("rst_fast_count", f_count, 32'd0);
    check("rst_ip", {24'd0, m_ip}, 32'd0);
    check("rst_ti", {31'd0, m_ti}, 32'd0);
    check("rst_sig", {31'd0, m_sig}, 32'd0);
    check("rst_vec", {29'd0, m_vec}, 32'd0);
    rd_chk("rst_cmp0", 8'h58, 32'hFFFF_FFFF);
    rd_chk("rst_cmp1", 8'h59, 32'hFFFF_FFFF);
    rd_chk("rst_cause", 8'h68, 32'd0);
    resetn = 1'b1;
    cyc(10);
    check("count_div2_10cyc", m_count, 32'd5);
    check("count_div1_10cyc", f_count, 32'd10);

    // Compare0 = 8, Count = 6: match four cycles later
    wr(8'h58, 32'd8);
    wr(8'h48, 32'd6);
    check("count_wr6", m_count, 32'd6);
    cyc(3);
    check("count_7", m_count, 32'd7);
    cyc(1);
    check("count_8", m_count, 32'd8);
    check("ti_before_match", {31'd0, m_ti}, 32'd0);
    cyc(1);
    check("ti_set", {31'd0, m_ti}, 32'd1);
    check("ip_lags_ti", {24'd0, m_ip}, 32'd0);
    cyc(1);
    check("ip7_timer", {24'd0, m_ip}, 32'h80);
    check("sig_timer", {31'd0, m_sig}, 32'd1);
    check("vec_timer", {29'd0, m_vec}, 32'd7);
    rd_chk("cause_rd_ti", 8'h68, 32'h4000_8000);
    wr(8'h58, 32'd100);
    check("ti_clr", {31'd0, m_ti}, 32'd0);
    cyc(1);
    check("sig_clr", {31'd0, m_sig}, 32'd0);
    check("ip_clr", {24'd0, m_ip}, 32'd0);
    rd_chk("cmp0_rd100", 8'h58, 32'd100);

    // Two channels: Compare1 fires first, then Compare0
    wr(8'h48, 32'd0);
    wr(8'h58, 32'd20);
    wr(8'h59, 32'd12);
    addr = 8'h59;
    #1;
    check("cmp1_rd", m_rd, 32'd12);
    check("fast_cmp1_unmapped", f_rd, 32'd0);
    addr = 8'h00;
    cyc(22);
    check("count_12", m_count, 32'd12);
    check("ti1_not_yet", {31'd0, m_ti}, 32'd0);
    cyc(1);
    check("ti1_set", {31'd0, m_ti}, 32'd1);
    cyc(16);
    check("count_20", m_count, 32'd20);
    wr(8'h59, 32'd1000);
    check("ti0_keeps_ti", {31'd0, m_ti}, 32'd1);
    wr(8'h58, 32'd1000);
    check("ti_all_clr", {31'd0, m_ti}, 32'd0);

    // Compare write on the match edge wins; same value re-arms next cycle
    wr(8'h48, 32'd50);
    wr(8'h58, 32'd52);
    cyc(3);
    check("count_52", m_count, 32'd52);
    check("ti_pre_match", {31'd0, m_ti}, 32'd0);
    wr(8'h58, 32'd52);
    check("cmp_wr_wins", {31'd0, m_ti}, 32'd0);
    cyc(1);
    check("ti_rearm", {31'd0, m_ti}, 32'd1);
    wr(8'h58, 32'd3000);
    check("ti_clr2", {31'd0, m_ti}, 32'd0);

    // Count write on a tick edge: written value, no +1, prescaler restarts
    wr(8'h48, 32'd50);
    cyc(1);
    wr(8'h48, 32'd200);
    check("cnt_wr_tick", m_count, 32'd200);
    check("fast_cnt_wr_tick", f_count, 32'd200);
    cyc(1);
    check("cnt_hold_after_wr", m_count, 32'd200);
    cyc(1);
    check("cnt_inc_after_wr", m_count, 32'd201);

    // Hardware interrupt path and software IP bits
    status_im = 8'h07;
    int_in = 6'b000001;
    cyc(2);
    check("hw_ip_2cyc", {24'd0, m_ip}, 32'd0);
    cyc(1);
    check("hw_ip_3cyc", {24'd0, m_ip}, 32'h04);
    check("hw_vec", {29'd0, m_vec}, 32'd2);
    check("hw_sig", {31'd0, m_sig}, 32'd1);
    wr(8'h68, 32'h0000_0300);
    check("sw_ip", {24'd0, m_ip}, 32'h07);
    check("sw_vec_hw", {29'd0, m_vec}, 32'd2);
    rd_chk("cause_rd_sw", 8'h68, 32'h0000_0700);
    int_in = 6'b000000;
    cyc(2);
    check("hw_fall_2cyc", {24'd0, m_ip}, 32'h07);
    cyc(1);
    check("hw_fall_3cyc", {24'd0, m_ip}, 32'h03);
    check("sw_vec", {29'd0, m_vec}, 32'd1);
    check("sw_sig", {31'd0, m_sig}, 32'd1);
    status_exl = 1'b1;
    #1;
    check("exl_mask", {31'd0, m_sig}, 32'd0);
    check("exl_vec", {29'd0, m_vec}, 32'd1);
    status_exl = 1'b0;
    wr(8'h68, 32'd0);
    check("sw_clr", {24'd0, m_ip}, 32'd0);

    // Count wrap and Compare = 0; read-during-write returns old value
    status_im = 8'h80;
    wr(8'h48, 32'hFFFF_FFFF);
    check("wrap_set", m_count, 32'hFFFF_FFFF);
    check("fast_wrap_set", f_count, 32'hFFFF_FFFF);
    mtc0 = 1'b1; addr = 8'h58; mtc0_data = 32'd0;
    #1;
    check("rd_during_wr", m_rd, 32'd3000);
    @(negedge clk);
    mtc0 = 1'b0; addr = 8'h00;
    check("wrap_hold", m_count, 32'hFFFF_FFFF);
    check("fast_wrap_0", f_count, 32'd0);
    check("fast_ti_clr", {31'd0, f_ti}, 32'd0);
    cyc(1);
    check("wrap_0", m_count, 32'd0);
    check("ti_cmp0_wait", {31'd0, m_ti}, 32'd0);
    check("fast_ti_cmp0", {31'd0, f_ti}, 32'd1);
    cyc(1);
    check("ti_cmp0", {31'd0, m_ti}, 32'd1);
    cyc(1);
    check("sig_pre_rst", {31'd0, m_sig}, 32'd1);

    // Asynchronous reset away from any clock edge
    #2;
    resetn = 1'b0;
    #1;
    check("arst_count", m_count, 32'd0);
    check("arst_fast_count", f_count, 32'd0);
    check("arst_ip", {24'd0, m_ip}, 32'd0);
    check("arst_ti", {31'd0, m_ti}, 32'd0);
    check("arst_sig", {31'd0, m_sig}, 32'd0);
    check("arst_vec", {29'd0, m_vec}, 32'd0);
    rd_chk("arst_cmp0", 8'h58, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
